fetch_align: RTL
================

# fetch_align

Instruction fetch alignment buffer sitting directly upstream of the decode stage. It fetches 64-bit words from the instruction memory port over a req/ack handshake, packs them into a 128-bit halfword-granular buffer, and always presents the next 64 bits of the instruction stream left-justified on `instOut`. Decode's `advance16/32/64` pulses pop 1, 2 or 4 halfwords. Branch redirects flush the buffer and restart fetch at any halfword-aligned PC.

## Interface
- `RESET_PC`, 64'h0: fetch PC after reset; bit 0 must be 0.
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `fetch_req`  out  1  memory request; held high until `fetch_ack`.
- `fetch_addr`  out  64  8-byte-aligned word address; stable while `fetch_req` is high.
- `fetch_ack`  in  1  response strobe; `fetch_data` valid this cycle.
- `fetch_data`  in  64  word; bits [63:48] are the lowest-address halfword.
- `redirect`  in  1  single-cycle flush/restart request.
- `redirect_pc`  in  64  new PC; bit 0 ignored (treated as 0).
- `advance16` / `advance32` / `advance64`  in  1 each  pop request from decode.
- `instOut`  out  64  buffer head, left-justified; feeds decode `instIn`.
- `inst_valid`  out  1  buffer holds the whole head instruction; drives the scheduler stall.
- `inst_pc`  out  64  PC of the head halfword.
- `starve_count`  out  32  present only with `FETCH_ALIGN_PERF_EN`.

## Operation
- Buffer: 128-bit register `buf` plus `count` (0..8 halfwords). Head is `buf[127:64]`; `instOut = buf[127:64]` masked so halfwords at index ≥ `count` read as zero.
- Head length from `instOut[63:62]`: `0x` → 1 halfword, `10` → 2, `11` → 4. `inst_valid = (count ≥ len) && !redirect_pending`.
- Pop: an advance is honoured only when `inst_valid` is high. It shifts `buf` left by 16·len bits, decrements `count` by len, and advances `inst_pc` by 2·len. Advances while `inst_valid` is low are ignored. More than one advance asserted at once is an illegal protocol; the largest one wins.
- Fill: on an accepted `fetch_ack`, the 64-bit word is written at halfword offset `count` (after that cycle's pop), minus any leading halfwords still to skip. `count` increases by the number of halfwords kept.
- Request policy: single outstanding request. Raise `fetch_req` when no request is pending and post-pop `count` ≤ 4. `fetch_addr` advances by 8 per acked word.
- States: IDLE (no request) and WAIT (request pending), plus flag `drop` (response belongs to a flushed stream).
- Redirect: clear `count`, set `inst_pc = redirect_pc`, `fetch_addr = {redirect_pc[63:3],3'b0}`, and skip = `redirect_pc[2:1]` leading halfwords of the next kept word.
  - If in WAIT without ack this cycle: set `drop`. The pending ack is discarded, then the new request issues.
  - Redirect has priority over a same-cycle advance and a same-cycle ack; both are discarded.
- Reset values: `count`=0, `buf`=0, `inst_pc`=`RESET_PC`, `fetch_addr`=`RESET_PC` aligned down, skip=`RESET_PC[2:1]`, `fetch_req`=0, `drop`=0, `starve_count`=0. So `instOut`=0 and `inst_valid`=0.

## Timing
- All outputs are registered except `inst_valid`, which is combinational from registers only. There is no combinational path from `advance*` or `fetch_ack` to any output.
- `fetch_req` rises the cycle after the condition holds; first request 1 cycle after reset release.
- Ack in cycle N → data visible on `instOut` and `inst_valid` in cycle N+1.
- Redirect in cycle N → `inst_valid`=0 in N+1; `fetch_req` with the new address in N+1 if IDLE, or the cycle after the dropped ack if in WAIT.
- Simultaneous pop and fill in one cycle are both applied: `count_next = count − len + kept`. This never exceeds 8 by construction.
- `rst_n` asserted mid-transaction aborts immediately; a stale ack after reset release is ignored because WAIT is not set.

## Configuration
- `FETCH_ALIGN_PERF_EN` defined: `starve_count` port exists and increments (saturating at 2^32−1) every cycle where `inst_valid`=0 and no redirect occurs.
- Not defined: the port and counter are absent; there is no other behavioural difference.

## Structure
- Shared package/header `raisin64_defs`: length encodings (LEN16/LEN32/LEN64 halfword counts), `FETCH_WORD_BYTES`=8, and a `RESET_PC` default constant.
- One sub-module, `fa_inst_len`: combinational `instOut[63:62]` → halfword length (1/2/4). Decode's advance logic uses the same encoding.

## Test plan
- Reset with `RESET_PC`=0, memory returns 0x0001_8002_0003_0004 with ack 1 cycle after req. Required: `instOut`=0x0001_8002_0003_0004 and `inst_valid`=1 in the cycle after ack. Then `advance16` → `inst_pc`=2, head=0x8002_0003_0004_xxxx.
- Stream of four 64-bit instructions (0xC000…), with `advance64` every valid cycle and 1-cycle memory. Required: no more than 1 bubble cycle between consecutive instructions; `fetch_addr` sequence 0, 8, 0x10, 0x18.
- Instruction straddling words: 32-bit instruction at PC 6 (halfwords 0x8123 | 0x4567 across two words). Required: `inst_valid` stays 0 until the second ack; then head = 0x8123_4567….
- Redirect to 0x1004 while a request to 0x10 is pending. Required: the 0x10 response is dropped; next `fetch_addr`=0x1000; first valid head is halfword index 2 of that word; `inst_pc`=0x1004.
- Redirect, advance and ack in the same cycle. Required: `count`=0, the ack data is discarded, and `inst_pc`=`redirect_pc`.
- With `FETCH_ALIGN_PERF_EN`, memory ack delayed 5 cycles after reset. Required: `starve_count`=6 at the first `inst_valid`.

Source files
------------

// File: rtl/raisin64_defs.sv
// raisin64_defs: definitions shared by the fetch/decode front end.
//   LEN16/LEN32/LEN64  instruction lengths in halfwords (1/2/4)
//   FETCH_WORD_BYTES   bytes per instruction-memory word
//   RESET_PC_DEFAULT   default fetch PC after reset
//   fa_state_e         fetch request state (IDLE / WAIT)
//   adv_len()          decode advance pulses -> halfwords popped
package raisin64_defs;

  localparam logic [3:0]  LEN16            = 4'd1;
  localparam logic [3:0]  LEN32            = 4'd2;
  localparam logic [3:0]  LEN64            = 4'd4;
  localparam int unsigned FETCH_WORD_BYTES = 8;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;

  typedef enum logic {
    FA_IDLE = 1'b0,
    FA_WAIT = 1'b1
  } fa_state_e;

  // Illegal multi-advance combinations resolve to the largest pop.
  function automatic logic [3:0] adv_len(input logic a16, input logic a32, input logic a64);
    logic [3:0] len;
    if (a64) begin
      len = LEN64;
    end else if (a32) begin
      len = LEN32;
    end else if (a16) begin
      len = LEN16;
    end else begin
      len = 4'd0;
    end
    return len;
  endfunction

endpackage

// File: rtl/fa_inst_len.sv
// fa_inst_len: decodes the two leading bits of an instruction into its
// length in halfwords. Same encoding decode uses for its advance pulses.
//   hdr  in  2  instOut[63:62] of the buffer head
//   len  out 4  1 (0x), 2 (10) or 4 (11) halfwords
module fa_inst_len
  import raisin64_defs::*;
(
  input  logic [1:0] hdr,
  output logic [3:0] len
);

  // Header bits to halfword length.
  always_comb begin
    len = LEN16;
    case (hdr)
      2'b00, 2'b01: len = LEN16;
      2'b10:        len = LEN32;
      2'b11:        len = LEN64;
      default:      len = LEN16;
    endcase
  end

endmodule

// File: rtl/fetch_align.sv
// fetch_align: instruction fetch alignment buffer in front of decode.
// Fetches 64-bit words over a single-outstanding req/ack port, packs them
// into a 128-bit halfword-granular buffer and presents the next 64 bits of
// the stream left-justified on instOut. Decode pops 1/2/4 halfwords with
// advance16/32/64; redirect flushes the buffer and restarts fetch at any
// halfword-aligned PC.
// Optional feature: define FETCH_ALIGN_PERF_EN to add the starve_count port.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   fetch_req/addr       memory request (held until ack), 8-byte aligned
//   fetch_ack/data       response strobe and word (bits 63:48 lowest halfword)
//   redirect/redirect_pc flush and restart at redirect_pc (bit 0 ignored)
//   advance16/32/64      pop request from decode
//   instOut              buffer head, halfwords beyond the fill read as zero
//   inst_valid           whole head instruction present
//   inst_pc              PC of the head halfword
//   starve_count         saturating count of starved cycles (perf build only)
module fetch_align
  import raisin64_defs::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        fetch_req,
  output logic [63:0] fetch_addr,
  input  logic        fetch_ack,
  input  logic [63:0] fetch_data,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  input  logic        advance16,
  input  logic        advance32,
  input  logic        advance64,
  output logic [63:0] instOut,
  output logic        inst_valid,
  output logic [63:0] inst_pc
`ifdef FETCH_ALIGN_PERF_EN
  ,
  output logic [31:0] starve_count
`endif
);

  logic [127:0] buf_r;
  logic [3:0]   count_r;
  logic [1:0]   skip_r;
  logic [63:0]  inst_pc_r;
  logic [63:0]  fetch_addr_r;
  logic [63:0]  redir_addr_r;
  logic         fetch_req_r;
  logic         drop_r;
  fa_state_e    state_r;

  logic [127:0] buf_next_s;
  logic [127:0] popped_buf_s;
  logic [127:0] fill_buf_s;
  logic [63:0]  word_s;
  logic [63:0]  redir_aligned_s;
  logic [3:0]   count_next_s;
  logic [3:0]   popped_count_s;
  logic [3:0]   adv_len_s;
  logic [3:0]   pop_len_s;
  logic [3:0]   head_len_s;
  logic [3:0]   kept_s;
  logic         ack_take_s;
  logic         fill_s;
  logic         unused_pc_bit_s;

  fa_inst_len u_inst_len (
    .hdr (buf_r[127:126]),
    .len (head_len_s)
  );

  // A response destined for a flushed stream keeps the head invalid.
  assign inst_valid      = (count_r >= head_len_s) && !drop_r;
  assign redir_aligned_s = {redirect_pc[63:3], 3'b000};
  assign unused_pc_bit_s = redirect_pc[0];

  // Pop and fill datapath. Halfwords beyond count_r are kept at zero, so
  // the head can be driven straight from the register without a mask.
  always_comb begin
    adv_len_s = adv_len(advance16, advance32, advance64);
    if (inst_valid && (adv_len_s <= count_r)) begin
      pop_len_s = adv_len_s;
    end else begin
      pop_len_s = 4'd0;
    end
    popped_buf_s   = buf_r << {pop_len_s[2:0], 4'b0000};
    popped_count_s = count_r - pop_len_s;

    ack_take_s = (state_r == FA_WAIT) && fetch_ack;
    fill_s     = ack_take_s && !drop_r && !redirect;
    kept_s     = 4'd4 - {2'b00, skip_r};
    // Discard leading halfwords of the first word after a redirect, then
    // place the rest right behind what survives this cycle's pop. The
    // request policy guarantees popped_count_s <= 4 whenever a fill lands.
    word_s     = fetch_data << {skip_r, 4'b0000};
    fill_buf_s = {word_s, 64'h0} >> {popped_count_s[2:0], 4'b0000};

    if (redirect) begin
      buf_next_s   = 128'h0;
      count_next_s = 4'd0;
    end else if (fill_s) begin
      buf_next_s   = popped_buf_s | fill_buf_s;
      count_next_s = popped_count_s + kept_s;
    end else begin
      buf_next_s   = popped_buf_s;
      count_next_s = popped_count_s;
    end
  end

  // Fetch state machine with buffer, PC and request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_r        <= 128'h0;
      count_r      <= 4'd0;
      inst_pc_r    <= RESET_PC;
      fetch_addr_r <= {RESET_PC[63:3], 3'b000};
      redir_addr_r <= {RESET_PC[63:3], 3'b000};
      skip_r       <= RESET_PC[2:1];
      fetch_req_r  <= 1'b0;
      drop_r       <= 1'b0;
      state_r      <= FA_IDLE;
    end else begin
      buf_r   <= buf_next_s;
      count_r <= count_next_s;
      if (redirect) begin
        inst_pc_r <= {redirect_pc[63:1], 1'b0};
      end else begin
        inst_pc_r <= inst_pc_r + {59'd0, pop_len_s, 1'b0};
      end

      if (redirect) begin
        skip_r       <= redirect_pc[2:1];
        redir_addr_r <= redir_aligned_s;
        if ((state_r == FA_WAIT) && !fetch_ack) begin
          // Old request still in flight: keep its address stable and
          // throw its response away when it arrives.
          drop_r      <= 1'b1;
          state_r     <= FA_WAIT;
          fetch_req_r <= 1'b1;
        end else begin
          drop_r       <= 1'b0;
          fetch_addr_r <= redir_aligned_s;
          state_r      <= FA_WAIT;
          fetch_req_r  <= 1'b1;
        end
      end else begin
        case (state_r)
          FA_IDLE: begin
            if (count_next_s <= 4'd4) begin
              state_r     <= FA_WAIT;
              fetch_req_r <= 1'b1;
            end else begin
              state_r     <= FA_IDLE;
              fetch_req_r <= 1'b0;
            end
          end
          FA_WAIT: begin
            if (!fetch_ack) begin
              state_r     <= FA_WAIT;
              fetch_req_r <= 1'b1;
            end else if (drop_r) begin
              drop_r       <= 1'b0;
              fetch_addr_r <= redir_addr_r;
              state_r      <= FA_WAIT;
              fetch_req_r  <= 1'b1;
            end else begin
              fetch_addr_r <= fetch_addr_r + 64'(FETCH_WORD_BYTES);
              skip_r       <= 2'b00;
              if (count_next_s <= 4'd4) begin
                state_r     <= FA_WAIT;
                fetch_req_r <= 1'b1;
              end else begin
                state_r     <= FA_IDLE;
                fetch_req_r <= 1'b0;
              end
            end
          end
          default: begin
            state_r     <= FA_IDLE;
            fetch_req_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign fetch_req  = fetch_req_r;
  assign fetch_addr = fetch_addr_r;
  assign instOut    = buf_r[127:64];
  assign inst_pc    = inst_pc_r;

`ifdef FETCH_ALIGN_PERF_EN
  logic [31:0] starve_r;

  // Saturating count of cycles decode is starved outside of a redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_r <= 32'd0;
    end else if (!inst_valid && !redirect && (starve_r != 32'hFFFF_FFFF)) begin
      starve_r <= starve_r + 32'd1;
    end else begin
      starve_r <= starve_r;
    end
  end

  assign starve_count = starve_r;
`endif

endmodule
